// File: rtl/uart_tx_port.sv
// -----------------------------------------------------------------------------
// uart_tx_port
//
// Memory-mapped 8N1 serial transmitter. It is a target on the CPU's
// r / w / address_bus / data_bus interface. The CPU stores bytes into a small
// TX FIFO and the block serialises them on tx. The CPU can poll STATUS or
// use irq.
//
// Register window, 4 bytes at BASE_ADDR (offset = address_bus[1:0]):
//   0 DATA   W: push a byte (dropped and OVF set if the FIFO is full)
//            R: 8'h00
//   1 STATUS R: {1'b0, COUNT[2:0], OVF, BUSY, EMPTY, FULL}
//            W: any write clears OVF
//   2 DIV    R/W: clocks per bit minus 1
//   3 CTRL   R/W: bit0 TXEN, bit1 IRQEN; all other bits read 0
//
// Ports:
//   clk          system clock; all state changes on the falling edge
//   reset        asynchronous, active-high reset
//   address_bus  CPU address
//   data_bus     bidirectional CPU data bus, driven only while r && sel
//   r, w         CPU read / write strobes (level, active-high)
//   tx           serial line, registered, idle high
//   irq          transmit-done interrupt: IRQEN && EMPTY && FSM idle
//
// Bus handshake: the bus has no valid/ready pair and no wait states. A write
// is accepted on every falling clk edge where w && sel && !r, and the data is
// taken from data_bus at that edge. A read is purely combinational and has
// no side effects. Accesses outside the 4-byte window are ignored.
//
// FIFO_DEPTH_LOG2 must be 1 or 2, so COUNT always fits in STATUS[6:4].
// -----------------------------------------------------------------------------
module uart_tx_port #(
  parameter logic [15:0] BASE_ADDR       = 16'hFF00,
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter logic [7:0]  DIV_RESET       = 8'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_bus,
  inout  wire  [7:0]  data_bus,
  input  logic        r,
  input  logic        w,
  output logic        tx,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_ovf;
  logic [7:0]                 r_div;
  logic                       r_txen;
  logic                       r_irqen;

  logic [1:0]                 r_state;
  logic [7:0]                 r_timer;
  logic [7:0]                 r_div_lat;
  logic [7:0]                 r_shift;
  logic [2:0]                 r_bit_idx;
  logic                       r_tx;

  // ---------------------------------------------------------------------------
  // Decode and status
  // ---------------------------------------------------------------------------
  logic       w_sel;
  logic [1:0] w_off;
  logic       w_wr_en;
  logic       w_full;
  logic       w_empty;
  logic       w_busy;
  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;
  logic [7:0] w_head;
  logic [2:0] w_count3;
  logic [7:0] w_status;
  logic [7:0] w_rdata;

  assign w_sel   = (address_bus[15:2] == BASE_ADDR[15:2]);
  assign w_off   = address_bus[1:0];
  assign w_wr_en = w && w_sel && !r;

  // FULL/EMPTY come from the pre-edge count, so a push while full is dropped
  // even when the serializer pops on the same edge.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_busy  = (r_state != ST_IDLE);

  assign w_push    = w_wr_en && (w_off == OFF_DATA) && !w_full;
  assign w_bit_end = (r_timer == r_div_lat);

  // A pop starts a frame: either from idle, or at the very end of a stop bit
  // so that queued bytes go out back-to-back with no idle gap.
  assign w_pop = r_txen && !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  assign w_head   = r_mem[r_rd_ptr];
  assign w_count3 = 3'(r_count);
  assign w_status = {1'b0, w_count3, r_ovf, w_busy, w_empty, w_full};

  // ---------------------------------------------------------------------------
  // Read path (combinational, no side effects)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = 8'h00;
    case (w_off)
      OFF_DATA:   w_rdata = 8'h00;
      OFF_STATUS: w_rdata = w_status;
      OFF_DIV:    w_rdata = r_div;
      OFF_CTRL:   w_rdata = {6'b0, r_irqen, r_txen};
      default:    w_rdata = 8'h00;
    endcase
  end

  assign data_bus = (r && w_sel) ? w_rdata : 8'hzz;

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= DIV_RESET;
      r_txen  <= 1'b1;
      r_irqen <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_wr_en) begin
      case (w_off)
        OFF_DATA:   if (w_full) r_ovf <= 1'b1;
        OFF_STATUS: r_ovf <= 1'b0;
        OFF_DIV:    r_div <= data_bus;
        OFF_CTRL: begin
          r_txen  <= data_bus[0];
          r_irqen <= data_bus[1];
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  // Storage needs no reset: entries are only read once count says they hold
  // valid data.
  always_ff @(negedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_bus;
  end

  // Depth is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  //
  // r_timer counts 0..r_div_lat inside each bit, so every bit lasts
  // DIV+1 clocks. r_div_lat is captured at each frame start, which keeps a
  // mid-frame DIV write from stretching or shrinking the current frame.
  // r_tx is updated on the same edge as the state, so the line changes only
  // at bit boundaries and never glitches.
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= 8'd0;
      r_div_lat <= 8'd0;
      r_shift   <= 8'd0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_div_lat <= r_div;
            r_timer   <= 8'd0;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            // First data bit goes straight onto the line; the shifter then
            // holds the remaining bits with the next one in bit 0.
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= 3'd0;
            r_timer   <= 8'd0;
            r_state   <= ST_DATA;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_timer <= 8'd0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_timer <= 8'd0;
            if (w_pop) begin
              r_shift   <= w_head;
              r_div_lat <= r_div;
              r_tx      <= 1'b0;
              r_state   <= ST_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx  = r_tx;
  assign irq = r_irqen && w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_port.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_port
//
// Directed bench for uart_tx_port. The DUT updates on the falling edge, so
// the bench drives bus signals and samples tx/irq around the rising edge.
// Expected serial bits for each frame are built from the byte value in a
// queue and popped one clock at a time.
// -----------------------------------------------------------------------------
module tb_uart_tx_port;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address_bus;
  wire  [7:0]  data_bus;
  logic        r;
  logic        w;
  logic        tx;
  logic        irq;

  logic [7:0]  tb_data;
  logic        tb_drive;

  assign data_bus = tb_drive ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  uart_tx_port #(
    .BASE_ADDR       (16'hFF00),
    .FIFO_DEPTH_LOG2 (2),
    .DIV_RESET       (8'd15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .r           (r),
    .w           (w),
    .tx          (tx),
    .irq         (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One write, accepted on the next falling edge; returns 1ns after it.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    address_bus = a;
    tb_data     = d;
    tb_drive    = 1'b1;
    w           = 1'b1;
    @(negedge clk);
    #1;
    w        = 1'b0;
    tb_drive = 1'b0;
  endtask

  // Combinational read; takes 1ns and no clock edge.
  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    address_bus = a;
    r           = 1'b1;
    #1;
    d = data_bus;
    r = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [15:0] a,
                           input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Frame scoreboard: expected tx level per clock, start/data LSB first/stop.
  // pre_idle: the first sampled clock is still before the frame starts.
  // ---------------------------------------------------------------------------
  logic [0:0] exp_q[$];

  task automatic check_frame(input logic [7:0] b, input int div,
                             input bit pre_idle, input bit chk_busy,
                             input bit chk_irq);
    logic [0:0] e;
    logic [7:0] s;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      e = 1'b0;
      else if (i == 9) e = 1'b1;
      else             e = b[i-1];
      for (int k = 0; k <= div; k++) exp_q.push_back(e);
    end
    if (pre_idle) begin
      @(posedge clk);
      check_eq("tx_pre_idle", tx, 1'b1);
    end
    while (exp_q.size() > 0) begin
      @(posedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("tx_bit_%02h", b), tx, e);
      if (chk_busy) begin
        bus_read(16'hFF01, s);
        check_eq("busy_in_frame", s[2], 1'b1);
      end
      if (chk_irq) check_eq("irq_in_frame", irq, 1'b0);
    end
  endtask

  task automatic check_tx_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      check_eq(tag, tx, 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] d;

    reset       = 1'b1;
    r           = 1'b0;
    w           = 1'b0;
    address_bus = 16'h0000;
    tb_data     = 8'h00;
    tb_drive    = 1'b0;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    @(posedge clk);

    // Reset values
    check_reg("rst_status", 16'hFF01, 8'h02);
    check_reg("rst_ctrl",   16'hFF03, 8'h01);
    check_reg("rst_div",    16'hFF02, 8'h0F);
    check_reg("rst_data_rd", 16'hFF00, 8'h00);
    check_eq("rst_tx",  tx,  1'b1);
    check_eq("rst_irq", irq, 1'b0);

    // DUT releases the bus when r=0 or when unselected
    tb_data     = 8'hC3;
    tb_drive    = 1'b1;
    address_bus = 16'hFF01;
    #1;
    check_eq("hiz_r0", data_bus, 8'hC3);
    address_bus = 16'h1234;
    r           = 1'b1;
    #1;
    check_eq("hiz_unsel", data_bus, 8'hC3);
    r        = 1'b0;
    tb_drive = 1'b0;

    // Single frame, DIV=3, byte A5
    bus_write(16'hFF02, 8'h03);
    check_reg("div_rb", 16'hFF02, 8'h03);
    bus_write(16'hFF00, 8'hA5);
    check_eq("tx_after_wr", tx, 1'b1);
    check_frame(8'hA5, 3, 1'b1, 1'b1, 1'b0);
    check_tx_quiet("tx_idle_after_a5", 6);
    check_reg("status_after_a5", 16'hFF01, 8'h02);

    // Fill FIFO with TXEN off, overflow on the 5th byte
    bus_write(16'hFF02, 8'h00);
    bus_write(16'hFF03, 8'h00);
    for (int i = 1; i <= 5; i++) bus_write(16'hFF00, 8'(i));
    check_reg("status_full_ovf", 16'hFF01, 8'h49);
    check_tx_quiet("tx_txen_off", 4);

    // Enable: four back-to-back frames, byte 05 never sent
    bus_write(16'hFF03, 8'h01);
    check_frame(8'h01, 0, 1'b1, 1'b0, 1'b0);
    check_frame(8'h02, 0, 1'b0, 1'b0, 1'b0);
    check_frame(8'h03, 0, 1'b0, 1'b0, 1'b0);
    check_frame(8'h04, 0, 1'b0, 1'b0, 1'b0);
    check_tx_quiet("tx_no_byte5", 20);
    check_reg("status_ovf_sticky", 16'hFF01, 8'h0A);

    // Any STATUS write clears OVF; out-of-window writes are ignored
    bus_write(16'hFF01, 8'h5A);
    check_reg("status_ovf_clr", 16'hFF01, 8'h02);
    bus_write(16'hFF04, 8'h11);
    bus_write(16'h00FF, 8'h22);
    check_reg("status_no_alias", 16'hFF01, 8'h02);
    check_tx_quiet("tx_no_alias", 12);

    // IRQ
    bus_write(16'hFF03, 8'h03);
    check_reg("ctrl_rb", 16'hFF03, 8'h03);
    check_eq("irq_idle_empty", irq, 1'b1);
    bus_write(16'hFF00, 8'h5A);
    check_eq("irq_drop_on_push", irq, 1'b0);
    check_frame(8'h5A, 0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    check_eq("irq_after_frame", irq, 1'b1);
    check_eq("tx_after_irq_frame", tx, 1'b1);

    // Reset mid-frame during data bit 3 (byte F0 has bit3 = 0)
    bus_write(16'hFF03, 8'h01);
    bus_write(16'hFF02, 8'h03);
    bus_write(16'hFF00, 8'hF0);
    bus_write(16'hFF00, 8'h77);
    repeat (18) @(posedge clk);
    check_eq("tx_bit3_pre_rst", tx, 1'b0);
    check_reg("status_mid_frame", 16'hFF01, 8'h14);
    reset = 1'b1;
    #1;
    check_eq("tx_in_rst", tx, 1'b1);
    check_eq("irq_in_rst", irq, 1'b0);
    check_reg("status_in_rst", 16'hFF01, 8'h02);
    @(posedge clk);
    reset = 1'b0;
    check_tx_quiet("tx_after_rst", 45);
    check_reg("status_after_rst", 16'hFF01, 8'h02);
    check_reg("ctrl_after_rst", 16'hFF03, 8'h01);
    check_reg("div_after_rst",  16'hFF02, 8'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
